// File: rtl/axis_upsizer.sv
// axis_upsizer: packs RATIO narrow AXI-Stream beats into one wide beat; define AXIS_UPSIZER_SKID_EN for a registered s_ready via a one-entry skid
module axis_upsizer #(
  parameter int WORD_WIDTH = 16,
  parameter int S_WORDS = 1,
  parameter int RATIO = 4,
  parameter int CNT_W = 32
) (
  input  logic aclk,
  input  logic areset,
  output logic s_ready,
  input  logic s_valid,
  input  logic s_last,
  input  logic [S_WORDS*WORD_WIDTH-1:0] s_data,
  input  logic [S_WORDS-1:0] s_keep,
  input  logic m_ready,
  output logic m_valid,
  output logic m_last,
  output logic [S_WORDS*RATIO*WORD_WIDTH-1:0] m_data,
  output logic [S_WORDS*RATIO-1:0] m_keep,
  output logic [CNT_W-1:0] pkt_count
);
  localparam int BW = S_WORDS*WORD_WIDTH;
  localparam int CW = RATIO > 1 ? $clog2(RATIO) : 1;
  logic [CW-1:0] cnt;
  logic [RATIO*BW-1:0] acc_data, nxt_data;
  logic [RATIO*S_WORDS-1:0] acc_keep, nxt_keep;
  logic out_free, accept, in_valid, in_last, in_close, go;
  logic [BW-1:0] in_data;
  logic [S_WORDS-1:0] in_keep;
  assign out_free = !m_valid || m_ready;
  assign accept = s_valid && s_ready;
`ifdef AXIS_UPSIZER_SKID_EN
  logic skid_valid, skid_last;
  logic [BW-1:0] skid_data;
  logic [S_WORDS-1:0] skid_keep;
  assign s_ready = !skid_valid && !areset;
  assign in_valid = skid_valid || accept;
  assign in_last = skid_valid ? skid_last : s_last;
  assign in_data = skid_valid ? skid_data : s_data;
  assign in_keep = skid_valid ? skid_keep : s_keep;
  always_ff @(posedge aclk) begin
    if (areset) begin
      skid_valid <= 1'b0;
      skid_last <= 1'b0;
      skid_data <= '0;
      skid_keep <= '0;
    end else if (!skid_valid && accept && !go) begin
      skid_valid <= 1'b1;
      skid_last <= s_last;
      skid_data <= s_data;
      skid_keep <= s_keep;
    end else if (skid_valid && go) begin
      skid_valid <= 1'b0;
    end
  end
`else
  assign s_ready = out_free && !areset;
  assign in_valid = accept;
  assign in_last = s_last;
  assign in_data = s_data;
  assign in_keep = s_keep;
`endif
  assign in_close = cnt == CW'(RATIO-1) || in_last;
  // non-closing beats only touch the accumulator, so they never wait on the output
  assign go = in_valid && (out_free || !in_close);
  always_comb begin
    nxt_data = '0;
    nxt_keep = '0;
    for (int k = 0; k < RATIO; k++) begin
      nxt_data[k*BW +: BW] = k < int'(cnt) ? acc_data[k*BW +: BW] : k == int'(cnt) ? in_data : '0;
      nxt_keep[k*S_WORDS +: S_WORDS] = k < int'(cnt) ? acc_keep[k*S_WORDS +: S_WORDS] : k == int'(cnt) ? in_keep : '0;
    end
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt <= '0;
      acc_data <= '0;
      acc_keep <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      m_data <= '0;
      m_keep <= '0;
      pkt_count <= '0;
    end else begin
      if (m_valid && m_ready && m_last) pkt_count <= pkt_count + CNT_W'(1);
      if (go && in_close) begin
        m_valid <= 1'b1;
        m_last <= in_last;
        m_data <= nxt_data;
        m_keep <= nxt_keep;
        cnt <= '0;
        acc_keep <= '0;
      end else begin
        if (m_ready) m_valid <= 1'b0;
        if (go) begin
          acc_data[cnt*BW +: BW] <= in_data;
          acc_keep[cnt*S_WORDS +: S_WORDS] <= in_keep;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_axis_upsizer.sv
// tb_axis_upsizer: scoreboard bench; model groups accepted beats into wide beats from the packing rules
module tb_axis_upsizer;
  localparam int W = 16, S = 1, R = 4, CW = 32, BW = W*S;
  logic aclk = 0, areset = 1, s_ready, s_valid = 0, s_last = 0, m_ready = 1, m_valid, m_last;
  logic [BW-1:0] s_data = '0;
  logic [S-1:0] s_keep = '0;
  logic [R*BW-1:0] m_data;
  logic [R*S-1:0] m_keep;
  logic [CW-1:0] pkt_count;
  typedef struct packed {logic [R*BW-1:0] d; logic [R*S-1:0] k; logic l;} beat_t;
  beat_t exp_q[$];
  logic [BW-1:0] gd[$];
  logic [S-1:0] gk[$];
  int errors = 0, checks = 0, exp_pkts = 0, out_beats = 0;
  bit hold_rdy = 1, rand_rdy = 0, bp_done = 0;

  axis_upsizer #(.WORD_WIDTH(W), .S_WORDS(S), .RATIO(R), .CNT_W(CW)) dut (
    .aclk(aclk), .areset(areset), .s_ready(s_ready), .s_valid(s_valid), .s_last(s_last),
    .s_data(s_data), .s_keep(s_keep), .m_ready(m_ready), .m_valid(m_valid), .m_last(m_last),
    .m_data(m_data), .m_keep(m_keep), .pkt_count(pkt_count));

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [R*BW-1:0] act, input logic [R*BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge aclk) begin
    beat_t b, e;
    if (areset) begin
      gd.delete();
      gk.delete();
      exp_pkts = 0;
    end else if (s_valid && s_ready) begin
      gd.push_back(s_data);
      gk.push_back(s_keep);
      if (gd.size() == R || s_last) begin
        b = '0;
        for (int i = 0; i < gd.size(); i++) begin
          b.d[i*BW +: BW] = gd[i];
          b.k[i*S +: S] = gk[i];
        end
        b.l = s_last;
        exp_q.push_back(b);
        if (s_last) exp_pkts++;
        gd.delete();
        gk.delete();
      end
    end
    if (m_valid && m_ready) begin
      out_beats++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data %h with nothing expected", m_data);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", m_data, e.d);
        chk("m_keep", m_keep, e.k);
        chk("m_last", m_last, e.l);
      end
    end
  end

  initial forever begin
    @(posedge aclk);
    #2;
    m_ready = rand_rdy ? ($urandom_range(99) >= 20) : hold_rdy;
  end

  task automatic send(input logic [BW-1:0] d, input logic [S-1:0] k, input logic l);
    int n = 0;
    s_valid = 1; s_data = d; s_keep = k; s_last = l;
    do begin
      @(negedge aclk);
      n++;
    end while (!s_ready && n < 2000);
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: data %h never accepted", d);
    end
    @(posedge aclk);
    #1;
    s_valid = 0; s_last = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || gd.size() != 0) && n < 5000) begin
      @(posedge aclk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0 || gd.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected", exp_q.size());
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R*BW-1:0] cap_d;
    logic [R*S-1:0] cap_k;
    logic cap_l;
    int n, base_beats;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_s_ready", s_ready, 0);
    chk("reset_m_valid", m_valid, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_keep", m_keep, 0);
    chk("reset_pkt_count", pkt_count, 0);
    areset = 0;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 8; i++) send(BW'(i), 1, i == 7);
    drain();
    chk("t1_pkt_count", pkt_count, 1);
    for (int i = 0; i < 6; i++) send(BW'(i), 1, i == 5);
    drain();
    chk("t2_pkt_count", pkt_count, 2);
    send(9, 1, 1);
    chk("t3_latency_valid", m_valid, 1);
    chk("t3_data", m_data, 64'h9);
    chk("t3_keep", m_keep, 4'b0001);
    chk("t3_last", m_last, 1);
    drain();
    chk("t3_pkt_count", pkt_count, 3);
    hold_rdy = 0;
    @(posedge aclk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(BW'(100 + i), 1, i == 7);
        bp_done = 1;
      end
    join_none
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!m_valid && n < 100);
    cap_d = m_data; cap_k = m_keep; cap_l = m_last;
    chk("t4_first_data", cap_d, {16'd103, 16'd102, 16'd101, 16'd100});
    chk("t4_first_keep", cap_k, 4'b1111);
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      chk("t4_hold_data", m_data, cap_d);
      chk("t4_hold_keep", m_keep, cap_k);
      chk("t4_hold_last", m_last, cap_l);
      chk("t4_hold_valid", m_valid, 1);
    end
    chk("t4_s_ready_low", s_ready, 0);
    hold_rdy = 1;
    n = 0;
    while (!bp_done && n < 1000) begin
      @(posedge aclk);
      n++;
    end
    #1;
    chk("t4_sender_done", bp_done, 1);
    drain();
    chk("t4_pkt_count", pkt_count, 4);
    send(10, 1, 0);
    send(11, 1, 0);
    areset = 1;
    @(posedge aclk);
    #1;
    areset = 0;
    send(20, 1, 1);
    drain();
    chk("t5_pkt_count", pkt_count, 1);
    rand_rdy = 1;
    base_beats = out_beats;
    for (int i = 0; i < 404; i++) begin
      while ($urandom_range(99) < 5) begin
        @(posedge aclk);
        #1;
      end
      send(BW'(i), 1, i == 403);
    end
    drain();
    chk("t6_beat_count", out_beats - base_beats, 101);
    chk("t6_pkt_count", pkt_count, 2);
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(9, 1);
      for (int i = 0; i < n; i++) send(BW'($urandom), S'($urandom), i == n - 1);
    end
    drain();
    rand_rdy = 0;
    chk("t7_pkt_count", pkt_count, exp_pkts);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
Synthesizable AXI-Stream width up-converter.
- Packs RATIO consecutive narrow input beats of S_WORDS words each into one wide output beat of S_WORDS*RATIO words.
- Carries per-word keep through to the output.
- Closes a partial output beat early on s_last.
- Sits between the narrow DMA-side stream and the wide engine-side stream. Counts completed output packets for status readback.

Parameters:
WORD_WIDTH, 16, bits per word
S_WORDS, 1, words per input beat (>=1)
RATIO, 4, input beats per output beat (>=1)
CNT_W, 32, width of packet counter

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous reset, active-high
s_ready  out  1  input ready
s_valid  in  1  input valid
s_last  in  1  input end of packet
s_data  in  S_WORDS*WORD_WIDTH  input words, word 0 in LSBs
s_keep  in  S_WORDS  per-word keep
m_ready  in  1  output ready
m_valid  out  1  output valid
m_last  out  1  output end of packet
m_data  out  S_WORDS*RATIO*WORD_WIDTH  output words; slot k = input beat k of group, in bits [k*S_WORDS*WORD_WIDTH +: S_WORDS*WORD_WIDTH]
m_keep  out  S_WORDS*RATIO  per-word keep; slot k keep in [k*S_WORDS +: S_WORDS]
pkt_count  out  CNT_W  number of m_last beats accepted since reset, wraps at 2^CNT_W

Behaviour:
- Reset (areset=1 at posedge):
  - m_valid=0, m_last=0, m_data=0, m_keep=0, pkt_count=0.
  - Slot counter cnt=0; accumulator data and keep cleared to 0.
  - s_ready=0 while areset is high.
  - A partial group held at reset is discarded; no output is produced for it.
- Storage: accumulator (slots 0..RATIO-2) plus one output register.
- Handshake: out_free = !m_valid || m_ready. Base build: s_ready = out_free && !areset.
- Accepted input beat (s_valid && s_ready):
  - Written into slot cnt.
  - If cnt==RATIO-1 or s_last:
    - Group closes. Accumulator slots 0..cnt-1, the current beat in slot cnt, and zero data/keep in slots cnt+1..RATIO-1 load the output register.
    - m_valid=1 next cycle; m_last=s_last.
    - cnt returns to 0; accumulator keep is cleared.
  - Otherwise cnt increments.
- Latency: the closing input beat appears on m_* one cycle after its handshake.
- A beat with s_keep all zero still occupies its slot.
- Output register data, keep and last are held stable while m_valid && !m_ready.
- m_valid is deasserted after m_ready handshake unless a new group closes in the same cycle; in that case the new group loads with no bubble.
- pkt_count increments on each m_valid && m_ready && m_last.
- RATIO=1: every accepted beat closes a group; the block is a 1-cycle registered pass-through.
- Full throughput (one input beat per cycle) is sustained when m_ready is held high.

Optional Feature:
AXIS_UPSIZER_SKID_EN
- Defined: a one-entry input skid register is added and s_ready comes from a flop (s_ready = skid empty), so there is no combinational m_ready->s_ready path.
  - A beat accepted while !out_free and a group would close is held in the skid register.
  - s_ready drops the following cycle.
  - The skid register drains into the accumulator/output at the next out_free cycle, ahead of new input.
  - Ordering and keep behaviour are identical to the base build.
- Undefined: s_ready = out_free && !areset (combinational).

Test Plan:
1. WORD_WIDTH=16, S_WORDS=1, RATIO=4, m_ready=1; push 0..7 with s_last on 7.
   -> Two output beats, each one cycle after the 4th input of its group:
   - m_data words {3,2,1,0}, m_keep=4'b1111, m_last=0
   - m_data words {7,6,5,4}, m_keep=4'b1111, m_last=1
   - pkt_count=1
2. Push 0..5, s_last on 5.
   -> Second beat is words {0,0,5,4}, m_keep=4'b0011, m_last=1.
3. Single-word packet value 9 with s_last.
   -> Words {0,0,0,9}, m_keep=4'b0001, m_last=1 on the next cycle.
4. Backpressure: hold m_ready=0 for 10 cycles while the first beat is valid.
   -> m_data/m_keep/m_last stable all 10 cycles; s_ready=0 (base build); no input lost; order preserved after release.
5. Push 10,11 (no last), then pulse areset for 1 cycle, then push 20 with s_last.
   -> Only one output: words {0,0,0,20}, keep 4'b0001; pkt_count=1.
6. Random s_valid (5%) / m_ready (20%), 404 words 0..403 as a single packet.
   -> 101 output beats, all keep=4'b1111, word i == i, m_last only on beat 101.
   - Run with and without AXIS_UPSIZER_SKID_EN.
